level5_synth: RTL

LEVEL5_SYNTH -- requirements
Module: level5_synth

---
 rtl/level5_synth.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/level5_synth.sv
// Level-5 inverse Haar synthesis: buffered coefficient pairs expand to 32 samples, eight per beat.
// Optional build macro LEVEL5_SYNTH_ROUND_EN selects round-half-up instead of floor scaling.
module level5_synth #(
  parameter int unsigned W         = 17,
  parameter int unsigned SHIFT     = 5,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                Enable,
  input  logic                coef_valid,
  output logic                coef_ready,
  input  logic signed [W-1:0] cA_in,
  input  logic signed [W-1:0] cD_in,
  input  logic                coef_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] data_out1,
  output logic signed [W-1:0] data_out2,
  output logic signed [W-1:0] data_out3,
  output logic signed [W-1:0] data_out4,
  output logic signed [W-1:0] data_out5,
  output logic signed [W-1:0] data_out6,
  output logic signed [W-1:0] data_out7,
  output logic signed [W-1:0] data_out8,
  output logic [1:0]          beat,
  output logic [11:0]         pair_count,
  output logic                done
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PC_W  = 12;

  typedef struct packed {
    logic signed [W-1:0] ca;
    logic signed [W-1:0] cd;
    logic                last;
  } entry_t;

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t              state_q, state_d;
  entry_t              mem_q [BUF_DEPTH];
  entry_t              mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic signed [W-1:0] h0_q, h0_d, h1_q, h1_d, data_q, data_d;
  logic                last_q, last_d;
  logic [1:0]          beat_q, beat_d;
  logic [PC_W-1:0]     pcnt_q, pcnt_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;

  logic                push, pop, hs;
  entry_t              head;

  // Scaled sum/difference of one coefficient pair, W+1-bit intermediate.
  function automatic logic signed [W-1:0] synth(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b,
                                               input logic                sub);
    logic signed [W:0] s;
    s = sub ? ((W+1)'(a) - (W+1)'(b)) : ((W+1)'(a) + (W+1)'(b));
`ifdef LEVEL5_SYNTH_ROUND_EN
    begin
      logic signed [W+1:0] r;
      r = (W+2)'(s) + (W+2)'(2 ** (SHIFT - 1));
      return W'(r >>> SHIFT);
    end
`else
    return W'(s >>> SHIFT);
`endif
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  // Registered state.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      h0_q        <= '0;
      h1_q        <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      beat_q      <= '0;
      pcnt_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      data_q      <= data_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      pcnt_q      <= pcnt_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state, buffer and output logic.
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    h0_d     = h0_q;
    h1_d     = h1_q;
    data_d   = data_q;
    last_d   = last_q;
    beat_d   = beat_q;
    pcnt_d   = pcnt_q;
    pop      = 1'b0;
    push     = coef_valid && ready_q;
    hs       = out_valid_q && out_ready;
    head     = mem_q[rd_ptr_q];

    if (push) begin
      mem_d[wr_ptr_q] = '{ca: cA_in, cd: cD_in, last: coef_last};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      EMIT: begin
        if (hs) begin
          if (beat_q == 2'd3) begin
            if (pcnt_q != '1) pcnt_d = PC_W'(pcnt_q + 1'b1);
            if (last_q)                state_d = DONE;
            else if (count_q != '0)    pop = 1'b1;
            else                       state_d = IDLE;
          end else begin
            beat_d = 2'(beat_q + 2'd1);
            if (beat_q == 2'd1) data_d = h1_q;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // Loading a pair starts its first beat with h0 on the outputs.
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      h0_d     = synth(head.ca, head.cd, 1'b0);
      h1_d     = synth(head.ca, head.cd, 1'b1);
      last_d   = head.last;
      data_d   = h0_d;
      beat_d   = '0;
      state_d  = EMIT;
    end

    count_d = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));

    if (!Enable) begin
      state_d  = IDLE;
      mem_d    = '{default: '0};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      h0_d     = '0;
      h1_d     = '0;
      data_d   = '0;
      last_d   = 1'b0;
      beat_d   = '0;
      pcnt_d   = '0;
    end

    out_valid_d = (state_d == EMIT);
    done_d      = (state_d == DONE);
    ready_d     = Enable && (count_d < CNT_W'(BUF_DEPTH)) && (state_d != DONE);
  end

  assign coef_ready = ready_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign beat       = beat_q;
  assign pair_count = pcnt_q;
  assign data_out1  = data_q;
  assign data_out2  = data_q;
  assign data_out3  = data_q;
  assign data_out4  = data_q;
  assign data_out5  = data_q;
  assign data_out6  = data_q;
  assign data_out7  = data_q;
  assign data_out8  = data_q;

endmodule
